exec_sequencer: RTL and testbench

- Multi-cycle control FSM for the core. It steps one instruction at a time through fetch, decode, execute, optional memory wait and write-back.
- Each stage gets a one-cycle enable pulse; the FSM then waits for that stage's completion signal before moving on.
- It latches the execute stage's jump outcome, owns the program counter, and counts retired instructions.
- Sits at core top level, directly driving the enable inputs of the fetch, decode, execute and write stages.

---
 rtl/exec_sequencer.sv | 137 +++++++++++++
 tb/tb_exec_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: pulses each pipeline stage's enable, waits for its
// completion, owns the program counter and counts retired instructions.
module exec_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        fetch_enabled,
    input  logic        fetch_completed,
    output logic        decode_enabled,
    input  logic        decode_completed,
    input  logic        decode_halt,
    output logic        exec_enabled,
    input  logic        exec_completed,
    input  logic        exec_is_mem,
    input  logic        exec_is_jump,
    input  logic [31:0] exec_jump_dest,
    output logic        write_enabled,
    input  logic        write_completed,
    output logic [31:0] pc,
    output logic        running,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEMW   = 3'd4,
        WRITE  = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] MEM_WAIT_INIT = (MEM_LATENCY > 0) ? CW'(MEM_LATENCY - 1) : '0;

    state_t        state_q, state_d;
    logic          entry_q;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   count_q, count_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          jump_q;
    logic          mem_q;
    logic [31:0]   dest_q;
    logic          running_q;
    logic          halted_q;

    // entry_q marks the first cycle spent in a state; every stage state is only ever
    // entered from a different state, so a state change is the exact entry condition.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            entry_q   <= 1'b0;
            pc_q      <= RESET_PC;
            count_q   <= 32'd0;
            wait_q    <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            entry_q   <= (state_d != state_q);
            pc_q      <= pc_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            running_q <= (state_d != IDLE) && (state_d != HALT);
            halted_q  <= (state_d == HALT);
        end
    end

    // Execute-stage results are only valid in its enable cycle, so capture them there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            jump_q <= 1'b0;
            mem_q  <= 1'b0;
            dest_q <= 32'd0;
        end else if (state_q == EXEC && entry_q) begin
            jump_q <= exec_is_jump;
            mem_q  <= exec_is_mem;
            dest_q <= exec_jump_dest;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (!entry_q && fetch_completed) state_d = DECODE;
            end
            DECODE: begin
                if (!entry_q && decode_completed) state_d = decode_halt ? HALT : EXEC;
            end
            EXEC: begin
                if (!entry_q && exec_completed) begin
                    if (mem_q && (MEM_LATENCY > 0)) begin
                        state_d = MEMW;
                        wait_d  = MEM_WAIT_INIT;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            MEMW: begin
                if (wait_q == '0) state_d = WRITE;
                else              wait_d  = wait_q - 1'b1;
            end
            WRITE: begin
                if (!entry_q && write_completed) begin
                    state_d = FETCH;
                    pc_d    = jump_q ? dest_q : pc_q + 32'd1;
                    count_d = count_q + 32'd1;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign fetch_enabled  = (state_q == FETCH)  && entry_q;
    assign decode_enabled = (state_q == DECODE) && entry_q;
    assign exec_enabled   = (state_q == EXEC)   && entry_q;
    assign write_enabled  = (state_q == WRITE)  && entry_q;
    assign pc             = pc_q;
    assign instr_count    = count_q;
    assign running        = running_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: two instances (default parameters and a
// wrap/no-wait-state variant) share one stimulus stream selected by 'sel'.
module tb_exec_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, sel;
    logic        start, fc, dc, dh, ec, em, ej, wc;
    logic [31:0] ed;

    logic        feA, deA, eeA, weA, runA, haltA;
    logic [31:0] pcA, cntA;
    logic        feB, deB, eeB, weB, runB, haltB;
    logic [31:0] pcB, cntB;

    logic        fe, de, ee, we, running, halted;
    logic [31:0] pc, cnt;

    int assertions = 0;
    int failures   = 0;

    exec_sequencer #(.RESET_PC(32'h0), .MEM_LATENCY(2)) dutA (
        .clk(clk), .rstn(rstn), .start(start & ~sel),
        .fetch_enabled(feA), .fetch_completed(fc & ~sel),
        .decode_enabled(deA), .decode_completed(dc & ~sel), .decode_halt(dh & ~sel),
        .exec_enabled(eeA), .exec_completed(ec & ~sel), .exec_is_mem(em & ~sel),
        .exec_is_jump(ej & ~sel), .exec_jump_dest(sel ? 32'd0 : ed),
        .write_enabled(weA), .write_completed(wc & ~sel),
        .pc(pcA), .running(runA), .halted(haltA), .instr_count(cntA)
    );

    exec_sequencer #(.RESET_PC(32'hFFFF_FFFF), .MEM_LATENCY(0)) dutB (
        .clk(clk), .rstn(rstn), .start(start & sel),
        .fetch_enabled(feB), .fetch_completed(fc & sel),
        .decode_enabled(deB), .decode_completed(dc & sel), .decode_halt(dh & sel),
        .exec_enabled(eeB), .exec_completed(ec & sel), .exec_is_mem(em & sel),
        .exec_is_jump(ej & sel), .exec_jump_dest(sel ? ed : 32'd0),
        .write_enabled(weB), .write_completed(wc & sel),
        .pc(pcB), .running(runB), .halted(haltB), .instr_count(cntB)
    );

    assign fe      = sel ? feB   : feA;
    assign de      = sel ? deB   : deA;
    assign ee      = sel ? eeB   : eeA;
    assign we      = sel ? weB   : weA;
    assign running = sel ? runB  : runA;
    assign halted  = sel ? haltB : haltA;
    assign pc      = sel ? pcB   : pcA;
    assign cnt     = sel ? cntB  : cntA;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        start = 1'b0; fc = 1'b0; dc = 1'b0; dh = 1'b0;
        ec = 1'b0; em = 1'b0; ej = 1'b0; ed = 32'd0; wc = 1'b0;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag, input logic [31:0] expPc);
        checkOutput({tag, "_enables"}, {28'd0, fe, de, ee, we}, 32'd0);
        checkOutput({tag, "_pc"}, pc, expPc);
        checkOutput({tag, "_count"}, cnt, 32'd0);
        checkOutput({tag, "_flags"}, {30'd0, running, halted}, 32'd0);
    endtask

    // Called at a sample point where fetch_enabled is high. Each stage completes one
    // cycle after its enable. Returns when the next fetch_enabled is seen (cycles = steps
    // from FETCH entry) or when halted rises; gap = cycles between exec_completed and
    // write_enabled.
    task automatic runInstr(input logic isMem, input logic isJump, input logic [31:0] dest,
                            input logic isHalt, output int cycles, output int gap);
        logic pFe, pDe, pEe, pWe;
        int   ecT, weT;
        bit   done;
        pFe = 1'b0; pDe = 1'b0; pEe = 1'b0; pWe = 1'b0;
        ecT = -1; weT = -1; done = 1'b0; cycles = -1;
        checkOutput("instr_fetch_entry", {31'd0, fe}, 32'd1);
        for (int t = 0; t < 60 && !done; t++) begin
            clearInputs();
            if (pFe) fc = 1'b1;
            if (pDe) begin dc = 1'b1; dh = isHalt; end
            if (pEe) begin ec = 1'b1; ecT = t; end
            if (pWe) wc = 1'b1;
            if (ee) begin em = isMem; ej = isJump; ed = dest; end
            if (we) weT = t;
            if ((fe && t > 0) || halted) begin
                done   = 1'b1;
                cycles = t;
            end else begin
                pFe = fe; pDe = de; pEe = ee; pWe = we;
                stepCycle();
            end
        end
        gap = weT - ecT - 1;
        checkOutput("instr_completed_in_budget", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cyc, gap;
        sel  = 1'b0;
        rstn = 1'b0;
        clearInputs();

        // ---- DUT A: reset, three plain instructions, load+jump, halt ----
        stepCycle();
        checkResetState("reset_a", 32'h0);
        rstn = 1'b1;
        stepCycle();
        checkResetState("idle_a", 32'h0);
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        checkOutput("start_running", {31'd0, running}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            runInstr(1'b0, 1'b0, 32'd0, 1'b0, cyc, gap);
            checkOutput("plain_cycles", cyc, 32'd8);
            checkOutput("plain_pc", pc, i + 1);
        end
        checkOutput("plain_count", cnt, 32'd3);

        runInstr(1'b1, 1'b1, 32'd7, 1'b0, cyc, gap);
        checkOutput("load_memw_cycles", gap, 32'd2);
        checkOutput("load_total_cycles", cyc, 32'd10);
        checkOutput("load_jump_pc", pc, 32'd7);
        checkOutput("load_count", cnt, 32'd4);

        runInstr(1'b0, 1'b0, 32'd0, 1'b1, cyc, gap);
        checkOutput("halt_flags", {30'd0, running, halted}, 32'd1);
        checkOutput("halt_pc", pc, 32'd7);
        checkOutput("halt_count", cnt, 32'd4);
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            checkOutput("halt_no_enables", {28'd0, fe, de, ee, we}, 32'd0);
        end
        start = 1'b0;
        checkOutput("halt_sticky", {30'd0, running, halted}, 32'd1);

        // ---- DUT A: reset out of HALT, jump at pc 5, fetch stall, reset mid-DECODE ----
        rstn = 1'b0;
        #1;
        checkResetState("reset_from_halt", 32'h0);
        stepCycle();
        rstn = 1'b1;
        stepCycle();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) runInstr(1'b0, 1'b0, 32'd0, 1'b0, cyc, gap);
        checkOutput("pre_jump_pc", pc, 32'd5);
        runInstr(1'b0, 1'b1, 32'h40, 1'b0, cyc, gap);
        checkOutput("jump_pc", pc, 32'h40);
        checkOutput("jump_count", cnt, 32'd6);

        clearInputs();
        for (int k = 0; k < 10; k++) begin
            stepCycle();
            checkOutput("fetch_stall_enables", {28'd0, fe, de, ee, we}, 32'd0);
            checkOutput("fetch_stall_running", {31'd0, running}, 32'd1);
        end
        fc = 1'b1;
        stepCycle();
        fc = 1'b0;
        checkOutput("stall_release_decode_en", {31'd0, de}, 32'd1);
        checkOutput("stall_pc_hold", pc, 32'h40);
        #3;
        rstn = 1'b0;
        #1;
        checkResetState("async_reset_mid_decode", 32'h0);
        stepCycle();
        checkResetState("reset_held", 32'h0);

        // ---- DUT B: RESET_PC = FFFFFFFF, MEM_LATENCY = 0 ----
        sel = 1'b1;
        #1;
        checkResetState("reset_b", 32'hFFFF_FFFF);
        rstn = 1'b1;
        stepCycle();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        runInstr(1'b1, 1'b0, 32'd0, 1'b0, cyc, gap);
        checkOutput("nowait_memw_cycles", gap, 32'd0);
        checkOutput("nowait_total_cycles", cyc, 32'd8);
        checkOutput("wrap_pc", pc, 32'd0);
        checkOutput("wrap_count", cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
